// File: rtl/alu_operand_fetch_pkg.sv
// Shared constants for the ALU operand-fetch stage: datapath geometry, ALU select
// codes and the output-slot state encoding.
package alu_operand_fetch_pkg;

  localparam int unsigned DataWidth = 20;
  localparam int unsigned NumRegs   = 8;
  localparam int unsigned RegIdxW   = 3;

  // ALU output-select encoding
  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } slot_state_e;

  // A source is blocked when its producer is still in flight and is not
  // completing in this very cycle.
  function automatic logic src_blocked(input logic busy, input logic wb_hit);
    return busy & ~wb_hit;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one write port, entry 0 hardwired to zero.
module alu_regfile
  import alu_operand_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DataWidth,
  parameter int unsigned NREG  = NumRegs,
  localparam int unsigned IdxW = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IdxW-1:0]  raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [IdxW-1:0]  raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o,
  input  logic             we_i,
  input  logic [IdxW-1:0]  waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);

  logic [WIDTH-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: busy-bit scoreboard, writeback bypass and a one-entry
// output slot that sustains one instruction per cycle toward the ALU.
module alu_operand_fetch
  import alu_operand_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DataWidth,
  parameter int unsigned NREG  = NumRegs,
  localparam int unsigned IdxW = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_op_i,
  input  logic [IdxW-1:0]  in_rd_i,
  input  logic [IdxW-1:0]  in_rs1_i,
  input  logic [IdxW-1:0]  in_rs2_i,
  input  logic             in_imm_en_i,
  input  logic [WIDTH-1:0] in_imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       out_op_o,
  output logic [IdxW-1:0]  out_rd_o,
  output logic [WIDTH-1:0] out_a_o,
  output logic [WIDTH-1:0] out_b_o,
  input  logic             wb_en_i,
  input  logic [IdxW-1:0]  wb_rd_i,
  input  logic [WIDTH-1:0] wb_data_i
);

  slot_state_e      state_q;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [3:0]       out_op_q;
  logic [IdxW-1:0]  out_rd_q;
  logic [WIDTH-1:0] out_a_q, out_b_q;

  logic [WIDTH-1:0] rf_a, rf_b, op_a, op_b;
  logic             rs1_hit, rs2_hit, haz_rs1, haz_rs2, accept;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .raddr_a_i (in_rs1_i),
    .rdata_a_o (rf_a),
    .raddr_b_i (in_rs2_i),
    .rdata_b_o (rf_b),
    .we_i      (wb_en_i),
    .waddr_i   (wb_rd_i),
    .wdata_i   (wb_data_i)
  );

  assign rs1_hit = wb_en_i && (wb_rd_i == in_rs1_i) && (in_rs1_i != '0);
  assign rs2_hit = wb_en_i && (wb_rd_i == in_rs2_i) && (in_rs2_i != '0);

  assign haz_rs1 = src_blocked(busy_q[in_rs1_i], rs1_hit);
  assign haz_rs2 = ~in_imm_en_i & src_blocked(busy_q[in_rs2_i], rs2_hit);

  // Deliberately independent of in_valid_i.
  assign in_ready_o = ~haz_rs1 & ~haz_rs2 & ((state_q == StEmpty) | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  assign op_a = rs1_hit ? wb_data_i : rf_a;
  assign op_b = in_imm_en_i ? in_imm_i : (rs2_hit ? wb_data_i : rf_b);

  // Set on issue takes priority over clear on writeback to the same rd.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) begin
      busy_d[wb_rd_i] = 1'b0;
    end
    if (accept && (in_rd_i != '0)) begin
      busy_d[in_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StEmpty;
      out_op_q <= '0;
      out_rd_q <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_q <= StFull;
        StFull:  if (!accept && out_ready_i) state_q <= StEmpty;
      endcase
      if (accept) begin
        out_op_q <= in_op_i;
        out_rd_q <= in_rd_i;
        out_a_q  <= op_a;
        out_b_q  <= op_b;
      end
    end
  end

  assign out_valid_o = (state_q == StFull);
  assign out_op_o    = out_op_q;
  assign out_rd_o    = out_rd_q;
  assign out_a_o     = out_a_q;
  assign out_b_o     = out_b_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomised bench for alu_operand_fetch: a register/busy model predicts in_ready and
// the issued operand tuples, which a separate monitor compares at the output slot.
module tb_alu_operand_fetch;

  localparam int W = 20;

  typedef struct packed {
    logic [3:0]   op;
    logic [2:0]   rd;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } issue_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [3:0]   in_op = '0;
  logic [2:0]   in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic         in_imm_en = 1'b0;
  logic [W-1:0] in_imm = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [3:0]   out_op;
  logic [2:0]   out_rd;
  logic [W-1:0] out_a, out_b;
  logic         wb_en = 1'b0;
  logic [2:0]   wb_rd = '0;
  logic [W-1:0] wb_data = '0;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_regs [8];
  bit           m_busy [8];
  issue_t       exp_q [$];

  always #5 clk = ~clk;

  alu_operand_fetch dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_rd_i     (in_rd),
    .in_rs1_i    (in_rs1),
    .in_rs2_i    (in_rs2),
    .in_imm_en_i (in_imm_en),
    .in_imm_i    (in_imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_op_o    (out_op),
    .out_rd_o    (out_rd),
    .out_a_o     (out_a),
    .out_b_o     (out_b),
    .wb_en_i     (wb_en),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // One clock of stimulus: drive at negedge, predict at +1, commit model at +3
  // (after the monitor has consumed this cycle's drain at +2).
  task automatic cycle(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic ie,
                       input logic [W-1:0] imm, input logic ordy, input logic we,
                       input logic [2:0] wrd, input logic [W-1:0] wd);
    bit     hz1, hz2, rdy, acc;
    issue_t e;
    @(negedge clk);
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm_en = ie; in_imm = imm; out_ready = ordy;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    #1;
    hz1 = (rs1 != 0) && m_busy[rs1] && !(we && wrd == rs1);
    hz2 = !ie && (rs2 != 0) && m_busy[rs2] && !(we && wrd == rs2);
    rdy = !hz1 && !hz2 && (exp_q.size() == 0 || ordy);
    check("in_ready", 64'(in_ready), 64'(rdy));
    acc = v && rdy;
    e.op = op;
    e.rd = rd;
    e.a  = (rs1 == 0) ? '0 : ((we && wrd == rs1) ? wd : m_regs[rs1]);
    e.b  = ie ? imm : ((rs2 == 0) ? '0 : ((we && wrd == rs2) ? wd : m_regs[rs2]));
    #2;
    if (acc) exp_q.push_back(e);
    if (we && wrd != 0) begin
      m_regs[wrd] = wd;
      m_busy[wrd] = 1'b0;
    end
    if (acc && rd != 0) m_busy[rd] = 1'b1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, '0, ordy, 1'b0, 3'd0, '0);
  endtask

  task automatic wb(input logic [2:0] wrd, input logic [W-1:0] wd);
    cycle(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, '0, 1'b1, 1'b1, wrd, wd);
  endtask

  // Monitor: compares the presented slot against the oldest expected issue each
  // cycle, and retires it when the ALU takes it.
  initial begin
    issue_t act;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (out_valid) begin
          act = '{op: out_op, rd: out_rd, a: out_a, b: out_b};
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'(0));
          end else begin
            check("out_fields", 64'(act), 64'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          check("missing_out_valid", 64'(exp_q.size()), 64'(0));
        end
      end
    end
  end

  initial begin
    model_clear();
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_a", 64'(out_a), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic issue
    wb(3'd3, 20'h00012);
    cycle(1'b1, 4'b0010, 3'd5, 3'd3, 3'd0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0);
    idle(1'b1);
    // RAW stall on r5, released by a bypassed writeback
    repeat (3) cycle(1'b1, 4'h1, 3'd6, 3'd5, 3'd0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    cycle(1'b1, 4'h1, 3'd6, 3'd5, 3'd0, 1'b0, '0, 1'b1, 1'b1, 3'd5, 20'hFFFFF);
    // Backpressure, then drain with back-to-back acceptance
    repeat (4) cycle(1'b1, 4'h3, 3'd1, 3'd0, 3'd0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0);
    cycle(1'b1, 4'h3, 3'd1, 3'd0, 3'd0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    cycle(1'b1, 4'h4, 3'd7, 3'd3, 3'd0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    // Immediate operand, rd 0 and writes to reg 0
    cycle(1'b1, 4'h0, 3'd0, 3'd0, 3'd2, 1'b1, 20'hABCDE, 1'b1, 1'b0, 3'd0, '0);
    wb(3'd0, 20'h5A5A5);
    cycle(1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    // Simultaneous set/clear on r2
    cycle(1'b1, 4'h2, 3'd2, 3'd0, 3'd0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    cycle(1'b1, 4'h2, 3'd2, 3'd0, 3'd0, 1'b0, '0, 1'b1, 1'b1, 3'd2, 20'h00777);
    repeat (2) cycle(1'b1, 4'h5, 3'd3, 3'd2, 3'd0, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    wb(3'd2, 20'h00888);
    cycle(1'b1, 4'h5, 3'd3, 3'd2, 3'd1, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    repeat (2) wb(3'd3, 20'h0000A);

    // Reset mid-operation with r4 busy and the slot full
    wb(3'd4, 20'h12345);
    cycle(1'b1, 4'h6, 3'd4, 3'd0, 3'd0, 1'b0, '0, 1'b0, 1'b0, 3'd0, '0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy4", 64'(dut.busy_q[4]), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 4'h7, 3'd1, 3'd4, 3'd4, 1'b0, '0, 1'b1, 1'b0, 3'd0, '0);
    idle(1'b1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), 1'($urandom_range(0, 3) == 0), W'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom),
            W'($urandom));
    end

    repeat (3) idle(1'b1);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
